// File: rtl/ws2812_pkg.sv
// Shared constants for the ws2812 packet loader: FSM encoding, sync marker
// and the conversion from a microsecond timeout to clock cycles.
package ws2812_pkg;

  localparam logic [2:0] ST_SYNC  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int unsigned timeout_cycles(input int unsigned clk_mhz,
                                                 input int unsigned timeout_us);
    return clk_mhz * timeout_us;
  endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Single colour channel brightness scaler: out = (c * (brightness + 1)) >> 8.
// Brightness 255 passes the colour through unchanged, brightness 0 yields 0.
module ws2812_scale (
  input  logic [7:0] i_colour,
  input  logic [7:0] i_brightness,
  output logic [7:0] o_colour
);

  logic [15:0] w_product;

  // The +1 fits because 255 * 256 = 65280 still fits in 16 bits.
  assign w_product = 16'(i_colour) * (16'(i_brightness) + 16'd1);
  assign o_colour  = 8'(w_product >> 8);

endmodule

// File: rtl/ws2812_loader.sv
// Parses a byte stream (A5, START, COUNT, G/R/B triplets) into scaled
// per-LED writes for a downstream ws2812 driver.
module ws2812_loader
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_MHZ    = 12,
  parameter int TIMEOUT_US = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  brightness,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        frame_done,
  output logic        error
);

  localparam int unsigned TIMEOUT_CYC = timeout_cycles(CLK_MHZ, TIMEOUT_US);
  localparam int          TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]  NUM_LEDS_9  = 9'(NUM_LEDS);

  logic [2:0]    r_state;
  logic [7:0]    r_index;
  logic [7:0]    r_remaining;
  logic [7:0]    r_brightness;
  logic [7:0]    r_g;
  logic [7:0]    r_r;
  logic [1:0]    r_byte_idx;
  logic [TW-1:0] r_idle;
  logic [23:0]   r_rgb;
  logic [7:0]    r_led_num;
  logic          r_write;
  logic          r_frame_done;
  logic          r_error;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_timeout_zone;
  logic          w_timeout;
  logic [8:0]    w_end9;
  logic [7:0]    w_scaled_g;
  logic [7:0]    w_scaled_r;
  logic [7:0]    w_scaled_b;

  assign w_in_ready     = (r_state != ST_WRITE);
  assign w_accept       = in_valid && w_in_ready;
  assign w_timeout_zone = (r_state == ST_START) || (r_state == ST_COUNT) || (r_state == ST_DATA);
  assign w_timeout      = w_timeout_zone && !w_accept && (r_idle == IDLE_LAST);
  assign w_end9         = {1'b0, r_index} + {1'b0, in_data};

  // Blue is scaled straight from the incoming byte so the write can be
  // registered in the same cycle the triplet completes.
  ws2812_scale u_scale_g (.i_colour(r_g),     .i_brightness(r_brightness), .o_colour(w_scaled_g));
  ws2812_scale u_scale_r (.i_colour(r_r),     .i_brightness(r_brightness), .o_colour(w_scaled_r));
  ws2812_scale u_scale_b (.i_colour(in_data), .i_brightness(r_brightness), .o_colour(w_scaled_b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_SYNC;
      r_index      <= '0;
      r_remaining  <= '0;
      r_brightness <= '0;
      r_g          <= '0;
      r_r          <= '0;
      r_byte_idx   <= '0;
      r_idle       <= '0;
      r_rgb        <= '0;
      r_led_num    <= '0;
      r_write      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_write      <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;

      if (w_timeout_zone && !w_accept && !w_timeout) begin
        r_idle <= r_idle + TW'(1);
      end else begin
        r_idle <= '0;
      end

      if (w_timeout) begin
        r_error <= 1'b1;
        r_state <= ST_SYNC;
      end else begin
        case (r_state)
          ST_SYNC: begin
            if (w_accept && (in_data == SYNC_BYTE)) begin
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (w_accept) begin
              r_index <= in_data;
              if ({1'b0, in_data} >= NUM_LEDS_9) begin
                r_error <= 1'b1;
                r_state <= ST_SYNC;
              end else begin
                r_state <= ST_COUNT;
              end
            end
          end
          ST_COUNT: begin
            if (w_accept) begin
              r_remaining  <= in_data;
              r_brightness <= brightness;
              r_byte_idx   <= 2'd0;
              if (in_data == 8'd0) begin
                r_frame_done <= 1'b1;
                r_state      <= ST_SYNC;
              end else if (w_end9 > NUM_LEDS_9) begin
                r_error <= 1'b1;
                r_state <= ST_SYNC;
              end else begin
                r_state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (w_accept) begin
              case (r_byte_idx)
                2'd0: begin
                  r_g        <= in_data;
                  r_byte_idx <= 2'd1;
                end
                2'd1: begin
                  r_r        <= in_data;
                  r_byte_idx <= 2'd2;
                end
                default: begin
                  // frame_done rides with the final write of the packet.
                  r_rgb        <= {w_scaled_g, w_scaled_r, w_scaled_b};
                  r_led_num    <= r_index;
                  r_write      <= 1'b1;
                  r_frame_done <= (r_remaining == 8'd1);
                  r_byte_idx   <= 2'd0;
                  r_state      <= ST_WRITE;
                end
              endcase
            end
          end
          ST_WRITE: begin
            r_index     <= r_index + 8'd1;
            r_remaining <= r_remaining - 8'd1;
            r_state     <= (r_remaining == 8'd1) ? ST_SYNC : ST_DATA;
          end
          default: begin
            r_state <= ST_SYNC;
          end
        endcase
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign rgb_data   = r_rgb;
  assign led_num    = r_led_num;
  assign write      = r_write;
  assign frame_done = r_frame_done;
  assign error      = r_error;

endmodule
